dp_sequencer: RTL

- Multi-cycle control FSM that sits directly upstream of the datapath and replaces manual switch-driven control.
- Accepts one 16-bit instruction through a start/ready handshake.
- Decodes the instruction, then drives the datapath's control inputs and datapath_in across the register-read, execute and writeback stages, one stage per cycle.
- Outputs are Moore: a function of the current state and the latched instruction register (IR) only.

---
 rtl/dp_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for the register-file/ALU datapath.
// Accepts one instruction per start/ready handshake and issues Moore control outputs stage by stage.
module dp_sequencer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [15:0]   instr,
  output logic          w,
  output logic          bad,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          vsel,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic [DW-1:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  typedef enum logic [2:0] {
    K_MOVI,
    K_MOVR,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN,
    K_ILL
  } kind_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  kind_t       kind;
  logic        accept;

  // Instruction class from the opcode/op fields; everything unlisted is illegal.
  function automatic kind_t classify(input logic [15:0] v);
    kind_t k;
    case ({v[15:13], v[12:11]})
      5'b110_10: k = K_MOVI;
      5'b110_00: k = K_MOVR;
      5'b101_00: k = K_ADD;
      5'b101_01: k = K_CMP;
      5'b101_10: k = K_AND;
      5'b101_11: k = K_MVN;
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

  function automatic logic [1:0] alu_code(input kind_t k);
    logic [1:0] c;
    case (k)
      K_CMP:   c = ALU_SUB;
      K_AND:   c = ALU_AND;
      K_MVN:   c = ALU_NOTB;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  assign kind   = classify(ir);
  assign accept = (state == S_WAIT) && s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // IR is only loaded on accept so later changes on instr cannot disturb a running sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir  <= '0;
      bad <= 1'b0;
    end else if (accept) begin
      ir  <= instr;
      bad <= 1'b0;
    end else if (state == S_DECODE && kind == K_ILL) begin
      bad <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_WAIT: begin
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          K_MOVI:                next_state = S_WRITE_IMM;
          K_ADD, K_AND, K_CMP:   next_state = S_GET_A;
          K_MOVR, K_MVN:         next_state = S_GET_B;
          default:               next_state = S_WAIT;
        endcase
      end
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_EXEC;
      S_EXEC:      next_state = (kind == K_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: next_state = S_WAIT;
      S_WRITE_IMM: next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w           = 1'b0;
    readnum     = 3'b000;
    writenum    = 3'b000;
    write       = 1'b0;
    vsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = 2'b00;
    ALUop       = ALU_ADD;
    loadc       = 1'b0;
    loads       = 1'b0;
    datapath_in = sext8(ir[7:0]);
    case (state)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = ir[10:8];
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = ir[2:0];
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = ir[4:3];
        ALUop = alu_code(kind);
        asel  = (kind == K_MOVR);
        loadc = (kind != K_CMP);
        loads = (kind == K_CMP);
      end
      S_WRITE_REG: begin
        writenum = ir[7:5];
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = ir[10:8];
        write    = 1'b1;
        vsel     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
